// File: rtl/d_cache_pkg.sv
// d_cache_pkg: geometry of the direct-mapped L1 data cache.
//   Address split (LSB first): offset | index | tag.
//   Word select is the upper part of the offset. The two byte bits below it
//   are ignored because reads are word aligned.
package d_cache_pkg;

  localparam int VIRT_ADDR_W = 32;
  localparam int LINE_W      = 128;
  localparam int NLINES      = 4;
  localparam int MEM_ADDR_W  = 32;

  localparam int OFFSET_W = $clog2(LINE_W / 8);
  localparam int INDEX_W  = $clog2(NLINES);
  localparam int TAG_W    = VIRT_ADDR_W - INDEX_W - OFFSET_W;

  localparam int WORD_W   = 32;
  localparam int WORDS    = LINE_W / WORD_W;
  localparam int WSEL_W   = $clog2(WORDS);
  localparam int BYTE_W   = $clog2(WORD_W / 8);

  typedef logic [TAG_W-1:0]   tag_t;
  typedef logic [INDEX_W-1:0] index_t;
  typedef logic [WSEL_W-1:0]  wsel_t;
  typedef logic [LINE_W-1:0]  line_t;

endpackage

// File: rtl/d_cache_if.sv
// d_cache_if: bus between the load/store stage plus the memory model and the
// data cache.
//   wrt_en, addr, data_to_fill, mem_data_rdy  -> cache
//   data, cache_hit, req_dCache_mem,
//   req_dCache_mem_addr                       <- cache
// The slave modport is the cache side. The master modport is the
// core/memory side.
interface d_cache_if;
  import d_cache_pkg::*;

  logic                   wrt_en;
  logic [VIRT_ADDR_W-1:0] addr;
  logic [LINE_W-1:0]      data_to_fill;
  logic                   mem_data_rdy;
  logic [WORD_W-1:0]      data;
  logic                   cache_hit;
  logic                   req_dCache_mem;
  logic [MEM_ADDR_W-1:0]  req_dCache_mem_addr;

  modport slave (
    input  wrt_en, addr, data_to_fill, mem_data_rdy,
    output data, cache_hit, req_dCache_mem, req_dCache_mem_addr
  );

  modport master (
    output wrt_en, addr, data_to_fill, mem_data_rdy,
    input  data, cache_hit, req_dCache_mem, req_dCache_mem_addr
  );

endinterface

// File: rtl/d_cache.sv
// d_cache: direct-mapped, read-only L1 data cache with flop-based arrays.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active low. Clears the valid bits only.
//   bus    d_cache_if.slave
//            addr          byte address of the access
//            wrt_en and mem_data_rdy together write data_to_fill into the
//                          line at addr's index
//            cache_hit and data are combinational, so a hit takes 0 cycles
//            req_dCache_mem and req_dCache_mem_addr form the line-aligned
//                          miss request
// While reset is low, every output is held at zero.
module d_cache
  import d_cache_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  d_cache_if.slave bus
);

  // address fields
  index_t idx;
  tag_t   tag;
  wsel_t  wsel;
  logic [MEM_ADDR_W-1:0] line_addr;

  always_comb begin
    idx  = bus.addr[OFFSET_W +: INDEX_W];
    tag  = bus.addr[OFFSET_W+INDEX_W +: TAG_W];
    wsel = bus.addr[BYTE_W +: WSEL_W];
    // Clear the offset bits to form the line address sent to memory.
    line_addr = bus.addr[MEM_ADDR_W-1:0] & ~MEM_ADDR_W'((1 << OFFSET_W) - 1);
  end

  // storage
  logic [NLINES-1:0]             valid_q, valid_d;
  logic [NLINES-1:0][TAG_W-1:0]  tag_q,   tag_d;
  logic [NLINES-1:0][LINE_W-1:0] line_q,  line_d;

  // Reset has priority over a refill in the same cycle, so gate the refill
  // here. Then the data and tag arrays never change while reset is low.
  logic fill_en;
  assign fill_en = reset && bus.mem_data_rdy && bus.wrt_en;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    line_d  = line_q;
    if (fill_en) begin
      valid_d[idx] = 1'b1;
      tag_d[idx]   = tag;
      line_d[idx]  = bus.data_to_fill;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) valid_q <= '0;
    else        valid_q <= valid_d;
    tag_q  <= tag_d;
    line_q <= line_d;
  end

  // lookup
  logic  hit;
  line_t sel_line;

  always_comb begin
    sel_line = line_q[idx];
    hit      = reset && valid_q[idx] && (tag_q[idx] == tag);

    bus.cache_hit           = hit;
    bus.data                = hit ? sel_line[wsel*WORD_W +: WORD_W] : '0;
    bus.req_dCache_mem      = reset && !hit;
    bus.req_dCache_mem_addr = (reset && !hit) ? line_addr : '0;
  end

endmodule

// File: tb/tb_d_cache.sv
module tb_d_cache;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  d_cache_if bus();

  d_cache dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] FILL1 = 128'h0011_0101_0011_0101_0011_0101_0011_0101;
  localparam logic [127:0] FILL2 = 128'h4444_4444_3333_3333_2222_2222_1111_1111;

  // Reference model: each of the 4 slots records which line address
  // (addr>>4) it holds, and the line data.
  bit           m_valid [4];
  logic [27:0]  m_res   [4];
  logic [127:0] m_line  [4];

  initial for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) m_valid[i] <= 1'b0;
    end else if (bus.mem_data_rdy && bus.wrt_en) begin
      m_valid[bus.addr[5:4]] <= 1'b1;
      m_res[bus.addr[5:4]]   <= bus.addr[31:4];
      m_line[bus.addr[5:4]]  <= bus.data_to_fill;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (addr=%h t=%0t)", nm, act, exp, bus.addr, $time);
    end
  endtask

  // Compare the DUT against the model on every negedge.
  always @(negedge clk) begin
    logic [1:0]  ix;
    logic        e_hit, e_req;
    logic [31:0] e_data, e_addr;
    logic [127:0] ln;
    ix     = bus.addr[5:4];
    ln     = m_line[ix];
    e_hit  = (reset === 1'b1) && m_valid[ix] && (m_res[ix] == bus.addr[31:4]);
    e_data = e_hit ? ln[32*bus.addr[3:2] +: 32] : 32'h0;
    e_req  = (reset === 1'b1) && !e_hit;
    e_addr = e_req ? {bus.addr[31:4], 4'h0} : 32'h0;
    chk("model_hit",  {31'h0, bus.cache_hit},      {31'h0, e_hit});
    chk("model_data", bus.data,                    e_data);
    chk("model_req",  {31'h0, bus.req_dCache_mem}, {31'h0, e_req});
    chk("model_radr", bus.req_dCache_mem_addr,     e_addr);
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic rst, input logic [31:0] a, input logic rdy,
                       input logic wrt, input logic [127:0] f);
    reset = rst; bus.addr = a; bus.mem_data_rdy = rdy; bus.wrt_en = wrt;
    bus.data_to_fill = f;
  endtask

  // Hand-computed expectations, sampled at the next negedge, then advance one cycle.
  task automatic lit(input string nm, input logic h, input logic r,
                     input logic [31:0] ra, input logic [31:0] d);
    @(negedge clk);
    chk({nm, "_hit"},  {31'h0, bus.cache_hit},      {31'h0, h});
    chk({nm, "_req"},  {31'h0, bus.req_dCache_mem}, {31'h0, r});
    chk({nm, "_radr"}, bus.req_dCache_mem_addr,     ra);
    chk({nm, "_data"}, bus.data,                    d);
    cyc();
  endtask

  initial begin
    drive(1'b0, 32'h15, 1'b0, 1'b0, FILL1);
    lit("rst0", 0, 0, 32'h0, 32'h0);
    // 1: cold miss
    drive(1'b1, 32'h15, 1'b0, 1'b0, FILL1);
    lit("s1", 0, 1, 32'h10, 32'h0);
    // 2: refill index0, then hit on word0
    drive(1'b1, 32'h3, 1'b1, 1'b1, FILL1); cyc();
    drive(1'b1, 32'h0, 1'b0, 1'b0, FILL1);
    lit("s2", 1, 0, 32'h0, 32'h0011_0101);
    // 3: word2 and an unaligned byte address
    drive(1'b1, 32'hA, 1'b0, 1'b0, FILL1);
    lit("s3a", 1, 0, 32'h0, 32'h0011_0101);
    drive(1'b1, 32'h1, 1'b0, 1'b0, FILL1);
    lit("s3b", 1, 0, 32'h0, 32'h0011_0101);
    // 4: conflict on index0 evicts the old line
    drive(1'b1, 32'hF000_0000, 1'b0, 1'b0, FILL2);
    lit("s4a", 0, 1, 32'hF000_0000, 32'h0);
    drive(1'b1, 32'hF000_0000, 1'b1, 1'b1, FILL2); cyc();
    drive(1'b1, 32'hF000_000C, 1'b0, 1'b0, FILL2);
    lit("s4b", 1, 0, 32'h0, 32'h4444_4444);
    drive(1'b1, 32'hF000_0004, 1'b0, 1'b0, FILL2);
    lit("s4c", 1, 0, 32'h0, 32'h2222_2222);
    drive(1'b1, 32'h0, 1'b0, 1'b0, FILL2);
    lit("s4d", 0, 1, 32'h0, 32'h0);
    // 5: index1 misses, and half handshakes do not fill
    drive(1'b1, 32'h50, 1'b0, 1'b0, FILL1); lit("s5a", 0, 1, 32'h50, 32'h0);
    drive(1'b1, 32'h51, 1'b0, 1'b0, FILL1); lit("s5b", 0, 1, 32'h50, 32'h0);
    drive(1'b1, 32'h52, 1'b1, 1'b0, FILL1); lit("s5c", 0, 1, 32'h50, 32'h0);
    drive(1'b1, 32'h52, 1'b0, 1'b1, FILL1); lit("s5d", 0, 1, 32'h50, 32'h0);
    drive(1'b1, 32'h52, 1'b0, 1'b0, FILL1); lit("s5e", 0, 1, 32'h50, 32'h0);
    // 6: reset together with a refill; reset wins
    drive(1'b1, 32'h50, 1'b1, 1'b1, FILL2); cyc();
    drive(1'b1, 32'h58, 1'b0, 1'b0, FILL2); lit("s6a", 1, 0, 32'h0, 32'h3333_3333);
    drive(1'b0, 32'h50, 1'b1, 1'b1, FILL1); lit("s6b", 0, 0, 32'h0, 32'h0);
    drive(1'b1, 32'h50, 1'b0, 1'b0, FILL1); lit("s6c", 0, 1, 32'h50, 32'h0);
    drive(1'b1, 32'hF000_000C, 1'b0, 1'b0, FILL1); lit("s6d", 0, 1, 32'hF000_0000, 32'h0);

    // randomized phase: small tag pool to force hits and conflicts
    for (int n = 0; n < 3000; n++) begin
      logic [25:0] hi;
      logic [31:0] a;
      case ($urandom_range(0, 3))
        0: hi = 26'h0;
        1: hi = 26'h1;
        2: hi = 26'h3C0_0000;
        default: hi = 26'($urandom);
      endcase
      a = {hi, 6'($urandom)};
      drive(($urandom_range(0, 49) != 0), a, ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 2) == 0), {$urandom, $urandom, $urandom, $urandom});
      cyc();
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
